// File: rtl/rvfi_chk_pkg.sv
// Shared types for the RVFI shadow checker.
// Error codes and checker FSM states.
package rvfi_chk_pkg;

    localparam int REG_CNT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        HALTED = 2'd2,
        ERROR  = 2'd3
    } chk_state_e;

    typedef enum logic [2:0] {
        NONE       = 3'd0,
        RS1        = 3'd1,
        RS2        = 3'd2,
        RD0        = 3'd3,
        PC         = 3'd4,
        ORDER      = 3'd5,
        AFTER_HALT = 3'd6
    } err_code_e;

endpackage

// File: rtl/rvfi_shadow_regfile.sv
// Shadow copy of the architectural register file with per-entry valid bits.
// Two async read ports, one write port, synchronous clear of the valid bits.
module rvfi_shadow_regfile
    import rvfi_chk_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            i_clear,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr1,
    output logic [XLEN-1:0] o_rdata1,
    output logic            o_rvalid1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata2,
    output logic            o_rvalid2
);

    logic [XLEN-1:0]    r_data [REG_CNT];
    logic [REG_CNT-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_waddr] <= 1'b1;
            r_data[i_waddr]  <= i_wdata;
        end
    end

    assign o_rdata1  = r_data[i_raddr1];
    assign o_rvalid1 = r_valid[i_raddr1];
    assign o_rdata2  = r_data[i_raddr2];
    assign o_rvalid2 = r_valid[i_raddr2];

endmodule

// File: rtl/rvfi_shadow_checker.sv
// RVFI consumer checking operand reads, x0, PC continuity and order.
// Order check and err_order are built only with RVFI_SHADOW_ORDER_CHECK_EN.
module rvfi_shadow_checker
    import rvfi_chk_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rvfi_valid,
    input  logic [63:0]      rvfi_order,
    input  logic [ILEN-1:0]  rvfi_insn,
    input  logic             rvfi_trap,
    input  logic             rvfi_halt,
    input  logic             rvfi_intr,
    input  logic [4:0]       rvfi_rs1_addr,
    input  logic [4:0]       rvfi_rs2_addr,
    input  logic [XLEN-1:0]  rvfi_rs1_rdata,
    input  logic [XLEN-1:0]  rvfi_rs2_rdata,
    input  logic [4:0]       rvfi_rd_addr,
    input  logic [XLEN-1:0]  rvfi_rd_wdata,
    input  logic [XLEN-1:0]  rvfi_pc_rdata,
    input  logic [XLEN-1:0]  rvfi_pc_wdata,
    output logic [1:0]       chk_state,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [63:0]      err_order,
    output logic [CNT_W-1:0] retired_cnt
);

    chk_state_e       r_state, w_next;
    err_code_e        r_err_code, w_code;
    logic             r_err;
    logic             w_fire;
    logic [XLEN-1:0]  r_exp_pc;
    logic             r_pc_known;
    logic [CNT_W-1:0] r_cnt;

    logic [XLEN-1:0]  w_rs1_sh, w_rs2_sh;
    logic             w_rs1_v, w_rs2_v;
    logic             w_rs1_bad, w_rs2_bad, w_rd0_bad;
    logic             w_pc_bad, w_order_bad, w_halt_bad;
    logic             w_we;

    assign w_we = rvfi_valid && !rvfi_trap && (rvfi_rd_addr != 5'd0);

    rvfi_shadow_regfile #(.XLEN(XLEN)) u_rf (
        .clk      (clk),
        .i_clear  (!reset),
        .i_we     (w_we),
        .i_waddr  (rvfi_rd_addr),
        .i_wdata  (rvfi_rd_wdata),
        .i_raddr1 (rvfi_rs1_addr),
        .o_rdata1 (w_rs1_sh),
        .o_rvalid1(w_rs1_v),
        .i_raddr2 (rvfi_rs2_addr),
        .o_rdata2 (w_rs2_sh),
        .o_rvalid2(w_rs2_v)
    );

    assign w_rs1_bad = ((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != '0))
                    || (w_rs1_v && (rvfi_rs1_rdata != w_rs1_sh));
    assign w_rs2_bad = ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != '0))
                    || (w_rs2_v && (rvfi_rs2_rdata != w_rs2_sh));
    assign w_rd0_bad = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0);
    assign w_pc_bad  = r_pc_known && !rvfi_intr
                    && (rvfi_pc_rdata != r_exp_pc);
    assign w_halt_bad = (r_state == HALTED);

`ifdef RVFI_SHADOW_ORDER_CHECK_EN
    logic [63:0] r_exp_order;
    logic [63:0] r_err_order;

    assign w_order_bad = (r_state != IDLE) && (rvfi_order != r_exp_order);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_exp_order <= '0;
            r_err_order <= '0;
        end else if (rvfi_valid) begin
            r_exp_order <= rvfi_order + 64'd1;
            if (w_fire)
                r_err_order <= rvfi_order;
        end
    end

    assign err_order = r_err_order;
    logic w_unused;
    assign w_unused = ^rvfi_insn;
`else
    assign w_order_bad = 1'b0;
    assign err_order   = '0;
    logic w_unused;
    assign w_unused = ^{rvfi_insn, rvfi_order};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (rvfi_valid && (r_state != ERROR)) begin
            if (w_code != NONE)
                w_next = ERROR;
            else if (rvfi_halt)
                w_next = HALTED;
            else
                w_next = TRACK;
        end
    end

    // Error cause, lowest code wins
    always_comb begin
        w_code = NONE;
        if (w_rs1_bad)        w_code = RS1;
        else if (w_rs2_bad)   w_code = RS2;
        else if (w_rd0_bad)   w_code = RD0;
        else if (w_pc_bad)    w_code = PC;
        else if (w_order_bad) w_code = ORDER;
        else if (w_halt_bad)  w_code = AFTER_HALT;
        w_fire = rvfi_valid && (r_state != ERROR) && (w_code != NONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err      <= 1'b0;
            r_err_code <= NONE;
            r_exp_pc   <= '0;
            r_pc_known <= 1'b0;
            r_cnt      <= '0;
        end else if (rvfi_valid) begin
            r_exp_pc   <= rvfi_pc_wdata;
            r_pc_known <= !rvfi_trap;
            if (r_cnt != {CNT_W{1'b1}})
                r_cnt <= r_cnt + 1'b1;
            if (w_fire) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
            end
        end
    end

    assign chk_state   = r_state;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_rvfi_shadow_checker.sv
// Directed bench for rvfi_shadow_checker.
// Order expectations follow RVFI_SHADOW_ORDER_CHECK_EN.
module tb_rvfi_shadow_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rvfi_valid = 1'b0;
    logic [63:0] rvfi_order = '0;
    logic [31:0] rvfi_insn = '0;
    logic        rvfi_trap = 1'b0;
    logic        rvfi_halt = 1'b0;
    logic        rvfi_intr = 1'b0;
    logic [4:0]  rvfi_rs1_addr = '0;
    logic [4:0]  rvfi_rs2_addr = '0;
    logic [31:0] rvfi_rs1_rdata = '0;
    logic [31:0] rvfi_rs2_rdata = '0;
    logic [4:0]  rvfi_rd_addr = '0;
    logic [31:0] rvfi_rd_wdata = '0;
    logic [31:0] rvfi_pc_rdata = '0;
    logic [31:0] rvfi_pc_wdata = '0;
    logic [1:0]  chk_state;
    logic        err;
    logic [2:0]  err_code;
    logic [63:0] err_order;
    logic [31:0] retired_cnt;

    int n_vec = 0;
    int n_bad = 0;

    rvfi_shadow_checker dut (
        .clk           (clk),
        .reset         (reset),
        .rvfi_valid    (rvfi_valid),
        .rvfi_order    (rvfi_order),
        .rvfi_insn     (rvfi_insn),
        .rvfi_trap     (rvfi_trap),
        .rvfi_halt     (rvfi_halt),
        .rvfi_intr     (rvfi_intr),
        .rvfi_rs1_addr (rvfi_rs1_addr),
        .rvfi_rs2_addr (rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata),
        .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr  (rvfi_rd_addr),
        .rvfi_rd_wdata (rvfi_rd_wdata),
        .rvfi_pc_rdata (rvfi_pc_rdata),
        .rvfi_pc_wdata (rvfi_pc_wdata),
        .chk_state     (chk_state),
        .err           (err),
        .err_code      (err_code),
        .err_order     (err_order),
        .retired_cnt   (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rvfi_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // One retirement; outputs are sampled 1ns after the capturing edge
    task automatic retire(
        input logic [63:0] ord, input logic [31:0] pc, input logic [31:0] npc,
        input logic [4:0] rs1, input logic [31:0] rs1d,
        input logic [4:0] rs2, input logic [31:0] rs2d,
        input logic [4:0] rd, input logic [31:0] rdw,
        input logic trap, input logic halt, input logic intr);
        rvfi_valid     = 1'b1;
        rvfi_order     = ord;
        rvfi_insn      = 32'h0000_0013;
        rvfi_pc_rdata  = pc;
        rvfi_pc_wdata  = npc;
        rvfi_rs1_addr  = rs1;
        rvfi_rs1_rdata = rs1d;
        rvfi_rs2_addr  = rs2;
        rvfi_rs2_rdata = rs2d;
        rvfi_rd_addr   = rd;
        rvfi_rd_wdata  = rdw;
        rvfi_trap      = trap;
        rvfi_halt      = halt;
        rvfi_intr      = intr;
        @(posedge clk);
        #1;
        rvfi_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %0d want 0", err); end
        n_vec++; if (err_code !== 3'd0) begin n_bad++; $display("FAIL rst_code got %0d want 0", err_code); end
        n_vec++; if (err_order !== 64'd0) begin n_bad++; $display("FAIL rst_order got %0d want 0", err_order); end
        n_vec++; if (retired_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_cnt got %0d want 0", retired_cnt); end
        n_vec++; if (chk_state !== 2'd0) begin n_bad++; $display("FAIL rst_state got %0d want 0", chk_state); end
    endtask

    task automatic test_basic();
        do_reset();
        retire(0, 32'h0, 32'h4, 0, 0, 0, 0, 5'd1, 32'h5, 0, 0, 0);
        n_vec++; if (chk_state !== 2'd1) begin n_bad++; $display("FAIL basic_state1 got %0d want 1", chk_state); end
        retire(1, 32'h4, 32'h8, 5'd1, 32'h5, 0, 0, 5'd2, 32'hA, 0, 0, 0);
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL basic_err got %0d want 0", err); end
        n_vec++; if (retired_cnt !== 32'd2) begin n_bad++; $display("FAIL basic_cnt got %0d want 2", retired_cnt); end
        n_vec++; if (chk_state !== 2'd1) begin n_bad++; $display("FAIL basic_state got %0d want 1", chk_state); end
        // rs1 and rd both x2: read sees old 0xA, then shadow holds 0x7
        retire(2, 32'h8, 32'hC, 5'd2, 32'hA, 5'd1, 32'h5, 5'd2, 32'h7, 0, 0, 0);
        retire(3, 32'hC, 32'h10, 5'd2, 32'h7, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL rmw_err got %0d want 0", err); end
        n_vec++; if (retired_cnt !== 32'd4) begin n_bad++; $display("FAIL rmw_cnt got %0d want 4", retired_cnt); end
    endtask

    task automatic test_rs1();
        do_reset();
        retire(0, 32'h0, 32'h4, 0, 0, 0, 0, 5'd1, 32'h5, 0, 0, 0);
        retire(7, 32'h4, 32'h8, 5'd1, 32'h6, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL rs1_err got %0d want 1", err); end
        n_vec++; if (err_code !== 3'd1) begin n_bad++; $display("FAIL rs1_code got %0d want 1", err_code); end
`ifdef RVFI_SHADOW_ORDER_CHECK_EN
        n_vec++; if (err_order !== 64'd7) begin n_bad++; $display("FAIL rs1_order got %0d want 7", err_order); end
`else
        n_vec++; if (err_order !== 64'd0) begin n_bad++; $display("FAIL rs1_order got %0d want 0", err_order); end
`endif
        n_vec++; if (chk_state !== 2'd3) begin n_bad++; $display("FAIL rs1_state got %0d want 3", chk_state); end
    endtask

    task automatic test_x0();
        do_reset();
        retire(0, 32'h0, 32'h4, 0, 0, 0, 0, 5'd0, 32'h1, 0, 0, 0);
        n_vec++; if (err_code !== 3'd3) begin n_bad++; $display("FAIL rd0_code got %0d want 3", err_code); end
        // ERROR is absorbing: code frozen, counter still runs
        retire(1, 32'h4, 32'h8, 0, 0, 5'd0, 32'hFF, 0, 0, 0, 0, 0);
        n_vec++; if (err_code !== 3'd3) begin n_bad++; $display("FAIL sticky_code got %0d want 3", err_code); end
        n_vec++; if (retired_cnt !== 32'd2) begin n_bad++; $display("FAIL sticky_cnt got %0d want 2", retired_cnt); end
        do_reset();
        retire(0, 32'h0, 32'h4, 0, 0, 5'd0, 32'hFF, 0, 0, 0, 0, 0);
        n_vec++; if (err_code !== 3'd2) begin n_bad++; $display("FAIL rs2_code got %0d want 2", err_code); end
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL rs2_err got %0d want 1", err); end
    endtask

    task automatic test_pc();
        do_reset();
        retire(0, 32'h0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        retire(1, 32'h104, 32'h108, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (err_code !== 3'd4) begin n_bad++; $display("FAIL pc_code got %0d want 4", err_code); end
        do_reset();
        retire(0, 32'h0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        retire(1, 32'h104, 32'h108, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL pc_intr got %0d want 0", err); end
        do_reset();
        retire(0, 32'h0, 32'h100, 0, 0, 0, 0, 5'd3, 32'h9, 1, 0, 0);
        retire(1, 32'h200, 32'h204, 5'd3, 32'h7, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL pc_trap got %0d want 0", err); end
        n_vec++; if (chk_state !== 2'd1) begin n_bad++; $display("FAIL pc_trap_state got %0d want 1", chk_state); end
    endtask

    task automatic test_order();
        do_reset();
        retire(0, 32'h0, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        retire(2, 32'h4, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef RVFI_SHADOW_ORDER_CHECK_EN
        n_vec++; if (err_code !== 3'd5) begin n_bad++; $display("FAIL order_code got %0d want 5", err_code); end
        n_vec++; if (err_order !== 64'd2) begin n_bad++; $display("FAIL order_val got %0d want 2", err_order); end
`else
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL order_err got %0d want 0", err); end
        n_vec++; if (chk_state !== 2'd1) begin n_bad++; $display("FAIL order_state got %0d want 1", chk_state); end
`endif
    endtask

    task automatic test_halt();
        do_reset();
        retire(0, 32'h0, 32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        n_vec++; if (chk_state !== 2'd2) begin n_bad++; $display("FAIL halt_state got %0d want 2", chk_state); end
        retire(1, 32'h4, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (err_code !== 3'd6) begin n_bad++; $display("FAIL halt_code got %0d want 6", err_code); end
        n_vec++; if (chk_state !== 2'd3) begin n_bad++; $display("FAIL halt_err_state got %0d want 3", chk_state); end
        // Reset wins over a same-cycle retirement
        rvfi_valid = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        rvfi_valid = 1'b0;
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL hrst_err got %0d want 0", err); end
        n_vec++; if (err_code !== 3'd0) begin n_bad++; $display("FAIL hrst_code got %0d want 0", err_code); end
        n_vec++; if (err_order !== 64'd0) begin n_bad++; $display("FAIL hrst_order got %0d want 0", err_order); end
        n_vec++; if (retired_cnt !== 32'd0) begin n_bad++; $display("FAIL hrst_cnt got %0d want 0", retired_cnt); end
        n_vec++; if (chk_state !== 2'd0) begin n_bad++; $display("FAIL hrst_state got %0d want 0", chk_state); end
        // Shadow valid bits were cleared: stale x1 value is not checked
        retire(0, 32'h40, 32'h44, 5'd1, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL hrst_shadow got %0d want 0", err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rs1();
        test_x0();
        test_pc();
        test_order();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rvfi_shadow_checker.md
Name: rvfi_shadow_checker

Overview:
- Sequential RVFI consumer that sits directly downstream of the core's RVFI port, beside the ISA-spec checker in the formal/sim testbench.
- Keeps a shadow register file and the expected next PC/order from retired instructions.
- Flags when a retirement's operand reads, x0 semantics, PC continuity or order sequence contradict earlier retirements.
- Errors are sticky and reported registered. The bench asserts on them, or a sim dumps them.

Parameters:
- XLEN, 32, register/PC width
- ILEN, 32, instruction width
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- rvfi_valid  in  1  retirement strobe, one instruction per cycle max
- rvfi_order  in  64  retirement index
- rvfi_insn  in  ILEN  retired instruction word
- rvfi_trap  in  1  instruction trapped
- rvfi_halt  in  1  last instruction before halt
- rvfi_intr  in  1  first instruction of trap handler
- rvfi_rs1_addr / rvfi_rs2_addr  in  5  source register indices
- rvfi_rs1_rdata / rvfi_rs2_rdata  in  XLEN  source values read
- rvfi_rd_addr  in  5  destination index
- rvfi_rd_wdata  in  XLEN  destination value
- rvfi_pc_rdata / rvfi_pc_wdata  in  XLEN  PC of this instruction / next PC
- chk_state  out  2  FSM state
- err  out  1  sticky error flag
- err_code  out  3  first error cause
- err_order  out  64  rvfi_order of the failing retirement
- retired_cnt  out  CNT_W  retirements accepted

Behaviour:
- Reset (reset==0 at posedge):
  - chk_state=IDLE, err=0, err_code=0, err_order=0, retired_cnt=0.
  - All shadow valid bits cleared; pc_known=0.
  - Applies mid-operation and overrides a same-cycle rvfi_valid.
- FSM states:
  - IDLE=0: no retirement seen. First rvfi_valid goes to TRACK. Order and PC checks are skipped for this first retirement.
  - TRACK=1: all checks active.
  - HALTED=2: entered on a retirement with rvfi_halt=1. Any later rvfi_valid raises AFTER_HALT.
  - ERROR=3: entered on the first error. Absorbing until reset. retired_cnt still counts; no further err_* updates.
- Checks (combinational on inputs, results registered; err visible 1 cycle after the offending rvfi_valid). Priority when several fire, lowest code wins:
  - 1 RS1: rs1_addr==0 and rs1_rdata!=0; or shadow_valid[rs1] and rs1_rdata!=shadow[rs1].
  - 2 RS2: same rule for rs2.
  - 3 RD0: rd_addr==0 and rd_wdata!=0.
  - 4 PC: pc_known and !rvfi_intr and pc_rdata!=exp_pc.
  - 5 ORDER: rvfi_order!=exp_order.
  - 6 AFTER_HALT: valid while in HALTED.
- On an error: err=1, err_code=cause, err_order=rvfi_order, chk_state=ERROR.
- Updates on each accepted rvfi_valid:
  - If !trap and rd!=0: shadow[rd]=rd_wdata, valid bit set. The same-cycle read check uses the pre-update value.
  - exp_pc=pc_wdata; pc_known=!trap. After a trap the next PC is unknown.
  - exp_order=rvfi_order+1 (64-bit wrap permitted).
  - retired_cnt increments, saturating at all-ones.
- rvfi_valid==0: no state change.

Optional Feature:
- Macro RVFI_SHADOW_ORDER_CHECK_EN.
- Defined: ORDER check (code 5) active; err_order is meaningful.
- Undefined: exp_order register and ORDER check removed; err_order tied 0; remaining codes unchanged.

Decomposition:
- Package rvfi_chk_pkg:
  - chk_state_e (IDLE/TRACK/HALTED/ERROR).
  - err_code_e (NONE=0, RS1=1, RS2=2, RD0=3, PC=4, ORDER=5, AFTER_HALT=6).
  - Constant REG_CNT=32.
- One sub-module: rvfi_shadow_regfile. 32xXLEN with valid bits, two async read ports, one write port, synchronous clear.

Test Plan:
- Reset, retire addi x1 (order 0, pc 0x0, wdata 0x5), then add reading rs1=x1 rdata 0x5 (order 1, pc 0x4) -> err=0, retired_cnt=2, chk_state=TRACK.
- After x1=0x5, retire with rs1=x1 rdata 0x6 at order 7 -> next cycle err=1, err_code=1, err_order=7, chk_state=ERROR.
- Retire rd=x0 rd_wdata=0x1 -> err_code=3. Repeat with rs2=x0 rs2_rdata=0xFF -> err_code=2.
- pc_wdata=0x100, then next pc_rdata=0x104 with intr=0 -> err_code=4. Same with intr=1 -> no error. After a trap, any pc_rdata -> no error.
- Order 0 then order 2 -> err_code=5 with macro defined; no error with macro undefined.
- Retire with halt=1, then another rvfi_valid -> err_code=6. Assert reset=0 for one cycle -> all outputs 0, chk_state=IDLE.
